sparse_mm_scheduler: RTL and testbench
======================================

# sparse_mm_scheduler

Sequencing controller for the N×N matrix-multiply datapath. On a start pulse it streams both operand matrices out of two single-port read BRAMs (one-cycle read latency) into local operand registers. It then runs the i/j/k inner-product loop on one shared 8×8 multiplier-accumulator and emits each result element on a write strobe. It replaces the free-running, always-recomputing multiply with a start/busy/done-controlled schedule, and optionally skips zero products for sparse operands.

## Interface
- N, 3, matrix dimension (2..8)
- DW, 8, operand width
- RW, 16, result/accumulator width; sums wrap modulo 2^RW
- AW, 4, BRAM address width
- ADDR_BASE, 1, BRAM address of element [0][0]; element [r][c] sits at ADDR_BASE + r·N + c

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until the cycle after done
- done  out  1  one-cycle pulse coincident with the final res_we
- a_addr  out  AW  BRAM A read address
- b_addr  out  AW  BRAM B read address
- a_dout  in  DW  BRAM A read data, valid one cycle after a_addr
- b_dout  in  DW  BRAM B read data, valid one cycle after b_addr
- res_we  out  1  result write strobe
- res_addr  out  clog2(N·N)  result index i·N + j
- res_data  out  RW  C[i][j]
- mac_cnt  out  16  MACs performed in the last completed run; updated at done

## Operation
- **States:** IDLE → LOAD → COMPUTE → IDLE.
- **IDLE:**
  - start=1 → LOAD; clear mac_cnt accumulator.
  - Address outputs hold ADDR_BASE.
- **LOAD:**
  - Drive a_addr = b_addr = ADDR_BASE + idx for idx = 0..N·N−1, one per cycle.
  - Capture a_dout/b_dout into A[idx], B[idx] one cycle later.
  - Record per-element nonzero flags.
  - After the capture of idx N·N−1 → COMPUTE.
- **COMPUTE:**
  - Walk (i,j) in row-major order. For each, walk k ascending: acc ← (first k ? 0 : acc) + A[i][k]·B[k][j], one MAC per cycle.
  - Product is full 2·DW bits; the sum is truncated to RW bits.
  - After the last k of (i,j), present res_we/res_addr/res_data registered on the next cycle. The first MAC of the next element proceeds in that same cycle, with no bubble.
  - After element (N−1,N−1) is written → IDLE.
- **Start handling:** start while busy is ignored and does not queue.
- **Reset** (any state, mid-run included): state IDLE, busy=0, done=0, res_we=0, res_addr=0, res_data=0, mac_cnt=0, a_addr=b_addr=ADDR_BASE, operand registers cleared. A run interrupted by reset produces no further writes.

## Timing
- start sampled at edge 0; LOAD addresses drive cycles 1..N·N; last capture at edge N·N+1.
- Dense: N³ MAC cycles. Final res_we and done are high during cycle N·N+N³+1. For N=3 this is cycle 37.
- busy falls at the edge ending the done cycle. A new start is accepted at the first edge where busy=0 is observed.
- res_we pulses exactly N·N times per run, res_addr strictly ascending 0..N·N−1.

## Configuration
- **SPARSE_SKIP_EN undefined:** every (i,j) takes exactly N cycles; mac_cnt = N³.
- **SPARSE_SKIP_EN defined:**
  - For each (i,j), only k with A[i][k]≠0 and B[k][j]≠0 are visited. The next qualifying k is chosen by priority encoder in the same cycle.
  - An element with no qualifying k takes exactly one cycle and writes 0.
  - Element cycle count = max(1, qualifying k count); mac_cnt counts only performed MACs.
  - res_addr order and values are identical to the dense build.

## Test plan
- **Identity test:** A = identity, B = 1..9 (row-major), N=3, dense → nine writes with res_data 1..9 at addr 0..8; done at cycle 37; mac_cnt=27.
- **Wrap test:** A and B all 255, RW=16 → every res_data = 195075 mod 65536 = 64003.
- **Sparse test (SPARSE_SKIP_EN):**
  - Stimulus: A = diag(2,0,3), B all 1.
  - Required: rows 0 and 2 write 2 and 3, row 1 writes 0.
  - Required: mac_cnt=6; done at cycle 9+9+1=19.
- **Start-while-busy:** pulse start again at cycle 20 of a dense run → ignored; exactly nine res_we; a second start after busy falls produces an identical run.
- **Reset mid-run:** assert rst during COMPUTE after 4 writes → all outputs at reset values immediately; no further res_we; a fresh start completes normally.
- **All-zero operands (SPARSE_SKIP_EN):** → nine writes of 0 on consecutive cycles; mac_cnt=0; done at cycle 19.

Source files
------------

// File: rtl/sparse_mm_scheduler_if.sv
// Handshake, BRAM read and result-write bundle for sparse_mm_scheduler.
// The master side is the scheduler; the slave side is the BRAM/result environment.
interface sparse_mm_scheduler_if #(
    parameter int unsigned N  = 3,
    parameter int unsigned DW = 8,
    parameter int unsigned RW = 16,
    parameter int unsigned AW = 4
);
    localparam int unsigned MW = $clog2(N * N);

    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] a_dout;
    logic [DW-1:0] b_dout;
    logic          res_we;
    logic [MW-1:0] res_addr;
    logic [RW-1:0] res_data;
    logic [15:0]   mac_cnt;

    modport master (
        input  start, a_dout, b_dout,
        output busy, done, a_addr, b_addr, res_we, res_addr, res_data, mac_cnt
    );

    modport slave (
        output start, a_dout, b_dout,
        input  busy, done, a_addr, b_addr, res_we, res_addr, res_data, mac_cnt
    );
endinterface

// File: rtl/sparse_mm_scheduler.sv
// Start/busy/done matrix-multiply sequencer: loads A and B from BRAM, then runs i/j/k on one MAC.
// Define SPARSE_SKIP_EN to skip k terms where either operand is zero.
module sparse_mm_scheduler #(
    parameter int unsigned N         = 3,
    parameter int unsigned DW        = 8,
    parameter int unsigned RW        = 16,
    parameter int unsigned AW        = 4,
    parameter int unsigned ADDR_BASE = 1
) (
    input logic                   clk,
    input logic                   rst,
    sparse_mm_scheduler_if.master bus
);
    localparam int unsigned NN = N * N;
    localparam int unsigned MW = $clog2(NN);
    localparam int unsigned LW = $clog2(NN + 1);
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned PW = 2 * DW;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE} state_t;
    state_t state, state_d;

    logic [DW-1:0] a_mem [NN];
    logic [DW-1:0] b_mem [NN];
`ifdef SPARSE_SKIP_EN
    logic [NN-1:0] a_nz, b_nz;
`endif
    logic [LW-1:0] ld_cnt;
    logic          p1_vld, p2_vld;
    logic [MW-1:0] p1_idx, p2_idx;
    logic [CW-1:0] ci, cj, kpos;
    logic [RW-1:0] acc;
    logic [15:0]   mac_acc;

    logic [N-1:0]  qual;
    logic          found, more, last_elem, mac_en;
    logic [CW-1:0] kk;
    logic [PW-1:0] prod;
    logic [RW-1:0] sum;

    // Next-state logic; COMPUTE holds through the done cycle so busy covers it
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    if (ld_cnt == LW'(NN)) state_d = COMPUTE;
            COMPUTE: if (bus.done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Pick the lowest qualifying k at or after kpos, and whether another follows it
    always_comb begin
        qual  = '0;
        found = 1'b0;
        more  = 1'b0;
        kk    = '0;
        for (int unsigned k = 0; k < N; k++) begin
`ifdef SPARSE_SKIP_EN
            qual[k] = a_nz[MW'(ci * N + k)] & b_nz[MW'(k * N + cj)];
`else
            qual[k] = 1'b1;
`endif
        end
        for (int unsigned k = 0; k < N; k++) begin
            if (qual[k] && (CW'(k) >= kpos)) begin
                if (!found) begin
                    found = 1'b1;
                    kk    = CW'(k);
                end else begin
                    more = 1'b1;
                end
            end
        end
    end

    assign prod      = PW'(a_mem[MW'(ci * N + kk)]) * PW'(b_mem[MW'(kk * N + cj)]);
    assign sum       = ((kpos == '0) ? RW'(0) : acc) + RW'(prod);
    assign last_elem = (ci == CW'(N - 1)) && (cj == CW'(N - 1));
    assign mac_en    = (state == COMPUTE) && !bus.done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.res_we   <= 1'b0;
            bus.res_addr <= '0;
            bus.res_data <= '0;
            bus.mac_cnt  <= '0;
            bus.a_addr   <= AW'(ADDR_BASE);
            bus.b_addr   <= AW'(ADDR_BASE);
            for (int unsigned n = 0; n < NN; n++) begin
                a_mem[n] <= '0;
                b_mem[n] <= '0;
            end
`ifdef SPARSE_SKIP_EN
            a_nz <= '0;
            b_nz <= '0;
`endif
            ld_cnt  <= '0;
            p1_vld  <= 1'b0;
            p2_vld  <= 1'b0;
            p1_idx  <= '0;
            p2_idx  <= '0;
            ci      <= '0;
            cj      <= '0;
            kpos    <= '0;
            acc     <= '0;
            mac_acc <= '0;
        end else begin
            bus.res_we <= 1'b0;
            bus.done   <= 1'b0;
            bus.busy   <= (state_d != IDLE);
            p1_vld     <= 1'b0;
            p2_vld     <= p1_vld;
            p2_idx     <= p1_idx;

            // Read data lands one cycle after its address; p2 tracks that slot
            if (p2_vld) begin
                a_mem[p2_idx] <= bus.a_dout;
                b_mem[p2_idx] <= bus.b_dout;
`ifdef SPARSE_SKIP_EN
                a_nz[p2_idx]  <= |bus.a_dout;
                b_nz[p2_idx]  <= |bus.b_dout;
`endif
            end

            if (state == IDLE && bus.start) begin
                // Address ADDR_BASE+0 is already on the bus while idle
                ld_cnt  <= LW'(1);
                p1_vld  <= 1'b1;
                p1_idx  <= '0;
                ci      <= '0;
                cj      <= '0;
                kpos    <= '0;
                mac_acc <= '0;
            end

            if (state == LOAD) begin
                if (ld_cnt != LW'(NN)) begin
                    bus.a_addr <= AW'(ADDR_BASE) + AW'(ld_cnt);
                    bus.b_addr <= AW'(ADDR_BASE) + AW'(ld_cnt);
                    p1_vld     <= 1'b1;
                    p1_idx     <= MW'(ld_cnt);
                    ld_cnt     <= ld_cnt + LW'(1);
                end else begin
                    bus.a_addr <= AW'(ADDR_BASE);
                    bus.b_addr <= AW'(ADDR_BASE);
                end
            end

            if (mac_en) begin
                if (found) mac_acc <= mac_acc + 16'd1;
                if (more) begin
                    acc  <= sum;
                    kpos <= kk + CW'(1);
                end else begin
                    // Element complete; the next element's first MAC runs next cycle
                    bus.res_we   <= 1'b1;
                    bus.res_addr <= MW'(ci * N + cj);
                    bus.res_data <= found ? sum : '0;
                    kpos         <= '0;
                    if (cj == CW'(N - 1)) begin
                        cj <= '0;
                        ci <= ci + CW'(1);
                    end else begin
                        cj <= cj + CW'(1);
                    end
                    if (last_elem) begin
                        bus.done    <= 1'b1;
                        bus.mac_cnt <= mac_acc + 16'(found);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sparse_mm_scheduler.sv
// Scoreboard bench for sparse_mm_scheduler: reference matrix product pushed per run, monitor pops on res_we/done.
module tb_sparse_mm_scheduler;
    localparam int N         = 3;
    localparam int DW        = 8;
    localparam int RW        = 16;
    localparam int AW        = 4;
    localparam int ADDR_BASE = 1;
    localparam int NN        = N * N;
`ifdef SPARSE_SKIP_EN
    localparam bit SPARSE = 1'b1;
`else
    localparam bit SPARSE = 1'b0;
`endif

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int cyc;  int macs; } dn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sparse_mm_scheduler_if #(.N(N), .DW(DW), .RW(RW), .AW(AW)) bus ();

    sparse_mm_scheduler #(
        .N(N), .DW(DW), .RW(RW), .AW(AW), .ADDR_BASE(ADDR_BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int e0     = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    bit busy_chk = 1'b0;
    wr_t exp_q[$];
    dn_t dn_q[$];
    logic [DW-1:0] mem_a [1 << AW];
    logic [DW-1:0] mem_b [1 << AW];
    int ga [NN];
    int gb [NN];

    always @(posedge clk) edge_n++;

    // One-cycle-latency BRAM models
    always @(posedge clk) begin
        bus.a_dout <= mem_a[bus.a_addr];
        bus.b_dout <= mem_b[bus.b_addr];
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected writes and run summaries as the DUT presents them
    always @(negedge clk) begin
        wr_t w;
        dn_t d;
        if (!rst) begin
            if (busy_chk) begin
                check("busy_after_done", bus.busy, 0);
                busy_chk = 1'b0;
            end
            if (bus.res_we) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write_pending", exp_q.size(), 1);
                end else begin
                    w = exp_q.pop_front();
                    check("res_addr", bus.res_addr, w.addr);
                    check("res_data", bus.res_data, w.data);
                end
            end
            if (bus.done) begin
                done_cnt++;
                check("done_with_we", bus.res_we, 1);
                if (dn_q.size() == 0) begin
                    check("unexpected_done_pending", dn_q.size(), 1);
                end else begin
                    d = dn_q.pop_front();
                    check("done_cycle", edge_n - e0 + 1, d.cyc);
                    check("mac_cnt", bus.mac_cnt, d.macs);
                    check("writes_left_at_done", exp_q.size(), 0);
                end
                busy_chk = 1'b1;
            end
        end
    end

    // Reference: plain matrix product, element cycle cost from the skip rule
    function automatic void model_push();
        int  tot = 0;
        int  macs = 0;
        dn_t d;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                longint s = 0;
                int     q = 0;
                wr_t    w;
                for (int k = 0; k < N; k++) begin
                    s += longint'(ga[i*N+k]) * longint'(gb[k*N+j]);
                    if (ga[i*N+k] != 0 && gb[k*N+j] != 0) q++;
                end
                w.addr = i * N + j;
                w.data = int'(s % (longint'(1) << RW));
                exp_q.push_back(w);
                if (SPARSE) begin
                    tot  += (q == 0) ? 1 : q;
                    macs += q;
                end else begin
                    tot  += N;
                    macs += N;
                end
            end
        end
        d.cyc  = NN + tot + 1;
        d.macs = macs;
        dn_q.push_back(d);
    endfunction

    task automatic load_mem();
        for (int idx = 0; idx < NN; idx++) begin
            mem_a[ADDR_BASE + idx] = DW'(ga[idx]);
            mem_b[ADDR_BASE + idx] = DW'(gb[idx]);
        end
    endtask

    task automatic fill_random();
        for (int idx = 0; idx < NN; idx++) begin
            ga[idx] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 255));
            gb[idx] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 255));
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"},     bus.busy, 0);
        check({tag, "_done"},     bus.done, 0);
        check({tag, "_res_we"},   bus.res_we, 0);
        check({tag, "_res_addr"}, bus.res_addr, 0);
        check({tag, "_res_data"}, bus.res_data, 0);
        check({tag, "_mac_cnt"},  bus.mac_cnt, 0);
        check({tag, "_a_addr"},   bus.a_addr, ADDR_BASE);
        check({tag, "_b_addr"},   bus.b_addr, ADDR_BASE);
    endtask

    // One complete run; pulse_at > 0 re-asserts start during that cycle of the run
    task automatic run(input int pulse_at);
        int d0 = done_cnt;
        int w0 = wr_cnt;
        bit got = 1'b0;
        load_mem();
        model_push();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        e0 = edge_n;
        check("busy_after_start", bus.busy, 1);
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            bus.start = (pulse_at > 0 && edge_n - e0 + 1 == pulse_at);
            if (done_cnt != d0) got = 1'b1;
        end
        bus.start = 1'b0;
        if (!got) begin
            check("run_timeout_done_seen", done_cnt - d0, 1);
            exp_q.delete();
            dn_q.delete();
        end
        repeat (3) @(negedge clk);
        check("writes_per_run", wr_cnt - w0, NN);
        check("writes_outstanding", exp_q.size(), 0);
    endtask

    task automatic reset_mid();
        int  w0 = wr_cnt;
        bit  ok = 1'b0;
        load_mem();
        model_push();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        e0 = edge_n;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            if (wr_cnt - w0 >= 4) ok = 1'b1;
        end
        check("four_writes_before_reset", int'(ok), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset("midrst");
        exp_q.delete();
        dn_q.delete();
        w0 = wr_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("writes_after_reset", wr_cnt - w0, 0);
        check("busy_after_reset", bus.busy, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        for (int n = 0; n < (1 << AW); n++) begin
            mem_a[n] = DW'($urandom_range(0, 255));
            mem_b[n] = DW'($urandom_range(0, 255));
        end
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Identity times 1..9
        for (int idx = 0; idx < NN; idx++) begin
            ga[idx] = (idx / N == idx % N) ? 1 : 0;
            gb[idx] = idx + 1;
        end
        run(0);

        // Accumulator wrap
        for (int idx = 0; idx < NN; idx++) begin
            ga[idx] = 255;
            gb[idx] = 255;
        end
        run(0);

        // diag(2,0,3) times all-ones
        for (int idx = 0; idx < NN; idx++) begin
            ga[idx] = 0;
            gb[idx] = 1;
        end
        ga[0]        = 2;
        ga[NN - 1]   = 3;
        run(0);

        // All zero operands
        for (int idx = 0; idx < NN; idx++) begin
            ga[idx] = 0;
            gb[idx] = 0;
        end
        run(0);

        // Start while busy is ignored, then the same data again
        fill_random();
        run(SPARSE ? 12 : 20);
        run(0);

        repeat (6) begin
            fill_random();
            run(0);
        end

        fill_random();
        reset_mid();
        fill_random();
        run(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
